mips_muldiv_ctrl: RTL and testbench

//  Iterative multiply/divide sequencer and HI/LO register owner. Executes MULT/MULTU/DIV/DIVU

---
 rtl/mips_muldiv_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mips_muldiv_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_ctrl.sv
// mips_muldiv_ctrl: iterative multiply/divide sequencer and HI/LO register owner.
// Runs MULT/MULTU/DIV/DIVU one bit per cycle: shift-add for multiply,
// restoring subtract for divide. Also executes MTHI/MTLO in a single cycle.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   md_start, md_op    request strobe and opcode (0 MULT, 1 MULTU, 2 DIV, 3 DIVU,
//                      4 MTHI, 5 MTLO, 6/7 no-op)
//   md_rs, md_rt       operands (md_rs is also the MTHI/MTLO data)
//   md_flush           squash any in-flight op; drops a same-cycle request
//   md_busy            mul/div in progress, new requests ignored
//   md_done            one-cycle pulse when HI/LO take a mul/div result
//   md_hi, md_lo       HI/LO registers
//
// Optional feature macro: MULDIV_EARLY_TERM_EN -- multiplies leave CALC as soon
// as the remaining multiplier magnitude bits are all zero.
//
// state  | meaning
// IDLE   | waiting for a request; MTHI/MTLO handled here
// CALC   | one multiply/divide step per cycle, down-counter tracks steps
// FIX    | sign correction, HI/LO write on exit
module mips_muldiv_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              md_start,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] md_rs,
  input  logic [DATA_W-1:0] md_rt,
  input  logic              md_flush,
  output logic              md_busy,
  output logic              md_done,
  output logic [DATA_W-1:0] md_hi,
  output logic [DATA_W-1:0] md_lo
);

  localparam int W  = DATA_W;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // a: multiplicand shifted left (mul) / {|rs|, dividend-then-quotient} (div)
  // b: multiplier shifted right (mul) / divisor (div)
  // acc: product (mul) / partial remainder in the low half (div)
  logic [2*W-1:0] a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic           is_div_q, is_div_d;
  logic           is_sgn_q, is_sgn_d;
  logic           neg_rs_q, neg_rs_d;
  logic           neg_rt_q, neg_rt_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           done_q, done_d;

  logic           rs_neg, rt_neg;
  logic [W-1:0]   rs_mag, rt_mag;
  logic [2*W-1:0] mul_sum, prod;
  logic [W:0]     rem_sh;
  logic [W-1:0]   diff;
  logic           div_ok;
  logic [W-1:0]   quot_fix, rem_fix, rs_back;
  logic           calc_last;

  // Opcodes 0 and 2 are the signed variants.
  assign rs_neg = ~md_op[0] & md_rs[W-1];
  assign rt_neg = ~md_op[0] & md_rt[W-1];
  assign rs_mag = rs_neg ? -md_rs : md_rs;
  assign rt_mag = rt_neg ? -md_rt : md_rt;

  assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

  // Remainder stays below the divisor, so only the low W bits of the
  // difference matter when the trial subtract succeeds.
  assign rem_sh = {acc_q[W-1:0], a_q[W-1]};
  assign div_ok = rem_sh >= {1'b0, b_q};
  assign diff   = rem_sh[W-1:0] - b_q;

  assign prod     = (is_sgn_q & (neg_rs_q ^ neg_rt_q)) ? -acc_q : acc_q;
  assign quot_fix = (is_sgn_q & (neg_rs_q ^ neg_rt_q)) ? -a_q[W-1:0] : a_q[W-1:0];
  assign rem_fix  = (is_sgn_q & neg_rs_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
  // Divide-by-zero hands back the original dividend, rebuilt from its magnitude.
  assign rs_back  = neg_rs_q ? -a_q[2*W-1:W] : a_q[2*W-1:W];

`ifdef MULDIV_EARLY_TERM_EN
  assign calc_last = (cnt_q == '0) | (~is_div_q & (b_q[W-1:1] == '0));
`else
  assign calc_last = (cnt_q == '0);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    is_div_d = is_div_q;
    is_sgn_d = is_sgn_q;
    neg_rs_d = neg_rs_q;
    neg_rt_d = neg_rt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    if (md_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md_start) begin
            case (md_op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                state_d  = S_CALC;
                cnt_d    = CNT_LAST;
                is_div_d = md_op[1];
                is_sgn_d = ~md_op[0];
                neg_rs_d = rs_neg;
                neg_rt_d = rt_neg;
                b_d      = rt_mag;
                acc_d    = '0;
                a_d      = md_op[1] ? {rs_mag, rs_mag} : {{W{1'b0}}, rs_mag};
              end
              3'd4:    hi_d = md_rs;
              3'd5:    lo_d = md_rs;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (is_div_q) begin
            a_d   = {a_q[2*W-1:W], a_q[W-2:0], div_ok};
            acc_d = {{W{1'b0}}, (div_ok ? diff : rem_sh[W-1:0])};
          end else begin
            acc_d = mul_sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end
          if (calc_last) state_d = S_FIX;
          else           cnt_d   = cnt_q - CW'(1);
        end
        S_FIX: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (is_div_q) begin
            if (b_q == '0) begin
              hi_d = rs_back;
              lo_d = '1;
            end else begin
              hi_d = rem_fix;
              lo_d = quot_fix;
            end
          end else begin
            hi_d = prod[2*W-1:W];
            lo_d = prod[W-1:0];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      neg_rs_q <= 1'b0;
      neg_rt_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      is_div_q <= is_div_d;
      is_sgn_q <= is_sgn_d;
      neg_rs_q <= neg_rs_d;
      neg_rt_q <= neg_rt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign md_busy = (state_q != S_IDLE);
  assign md_done = done_q;
  assign md_hi   = hi_q;
  assign md_lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Bench for mips_muldiv_ctrl: fixed vector table, hand-written corner
// sequences and randomized ops checked against an arithmetic reference model.
module tb_mips_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_rs, md_rt;
  logic        md_flush;
  logic        md_busy, md_done;
  logic [31:0] md_hi, md_lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi, exp_lo;

  mips_muldiv_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op),
    .md_rs(md_rs), .md_rt(md_rt), .md_flush(md_flush),
    .md_busy(md_busy), .md_done(md_done), .md_hi(md_hi), .md_lo(md_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] rs,
                                         input logic [31:0] rt);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb;
    logic [63:0] r;
    r = '0;
    case (op)
      3'd0: begin
        sp = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
        r  = sp;
      end
      3'd1: r = {32'd0, rs} * {32'd0, rt};
      3'd2: begin
        if (rt == 32'd0) r = {rs, 32'hFFFFFFFF};
        else if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
        else begin
          sa = rs; sb = rt;
          r = {sa % sb, sa / sb};
        end
      end
      3'd3: begin
        if (rt == 32'd0) r = {rs, 32'hFFFFFFFF};
        else r = {rs % rt, rs / rt};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Cycles from the accepting edge to the md_done edge.
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] rt);
    int iters;
    logic [31:0] mag;
    iters = 32;
`ifdef MULDIV_EARLY_TERM_EN
    if (op <= 3'd1) begin
      mag = (op == 3'd0 && rt[31]) ? -rt : rt;
      iters = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) iters = i + 1;
    end
`else
    mag = rt;
    if (mag == 32'd0 && op > 3'd7) iters = 0;
`endif
    return iters + 1;
  endfunction

  // Issue a mul/div; optionally hammer md_start with junk while busy.
  task automatic do_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input bit junk, output int lat, output bit busy_ok);
    @(negedge clk);
    md_start = 1'b1; md_op = op; md_rs = rs; md_rt = rt;
    @(posedge clk); #1;
    md_start = 1'b0;
    lat = 0;
    busy_ok = md_busy && !md_done;
    while (!md_done && lat < 100) begin
      if (junk) begin
        md_start = 1'b1;
        md_op    = 3'($urandom_range(0, 7));
        md_rs    = $urandom;
        md_rt    = $urandom;
      end
      @(posedge clk); #1;
      lat++;
      if (!md_done && !md_busy) busy_ok = 1'b0;
    end
    md_start = 1'b0;
  endtask

  task automatic run_muldiv(input string nm, input logic [2:0] op, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [31:0] hi, input logic [31:0] lo,
                            input bit junk);
    int lat;
    bit busy_ok;
    do_op(op, rs, rt, junk, lat, busy_ok);
    check({nm, "_lat"}, 64'(lat), 64'(ref_lat(op, rt)));
    check({nm, "_busy"}, {63'd0, busy_ok}, 64'd1);
    check({nm, "_busy_at_done"}, {63'd0, md_busy}, 64'd0);
    check({nm, "_hilo"}, {md_hi, md_lo}, {hi, lo});
    exp_hi = hi; exp_lo = lo;
  endtask

  // Single-cycle ops (MTHI/MTLO/no-op), optionally with a same-cycle flush.
  task automatic do_short(input string nm, input logic [2:0] op, input logic [31:0] rs,
                          input bit flush);
    @(negedge clk);
    md_start = 1'b1; md_op = op; md_rs = rs; md_rt = $urandom; md_flush = flush;
    @(posedge clk); #1;
    md_start = 1'b0; md_flush = 1'b0;
    if (!flush && op == 3'd4) exp_hi = rs;
    if (!flush && op == 3'd5) exp_lo = rs;
    check({nm, "_busy"}, {62'd0, md_busy, md_done}, 64'd0);
    check({nm, "_hilo"}, {md_hi, md_lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int k;
    bit seen_done;
    logic [2:0] op;
    logic [31:0] rs, rt;
    logic [63:0] r;

    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5]  = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[6]  = '{3'd0, 32'd0,        32'd5,        32'd0,        32'd0};
    vecs[7]  = '{3'd0, 32'd5,        32'd0,        32'd0,        32'd0};
    vecs[8]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[9]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[10] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[11] = '{3'd1, 32'h00010000, 32'h00010000, 32'd1,        32'd0};

    rst = 1'b1; md_start = 1'b0; md_op = 3'd0; md_rs = '0; md_rt = '0; md_flush = 1'b0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {md_busy, md_done, md_hi, md_lo}, 66'd0);
    @(negedge clk); rst = 1'b0;

    // Fixed vectors; back-to-back issue also exercises acceptance in the done cycle.
    for (int i = 0; i < 12; i++)
      run_muldiv($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                 vecs[i].hi, vecs[i].lo, (i % 3) == 1);

    // Done pulse lasts exactly one cycle.
    @(posedge clk); #1;
    check("done_pulse_width", {63'd0, md_done}, 64'd0);

    // MTHI then MTLO back to back, busy never high.
    do_short("mthi", 3'd4, 32'h1234, 1'b0);
    do_short("mtlo", 3'd5, 32'h5678, 1'b0);
    do_short("noop6", 3'd6, 32'hDEADBEEF, 1'b0);
    do_short("noop7", 3'd7, 32'hCAFEF00D, 1'b0);

    // MULTU flushed at cycle 5: idle next cycle, HI/LO untouched, no done.
    @(negedge clk);
    md_start = 1'b1; md_op = 3'd1; md_rs = 32'hFFFFFFFF; md_rt = 32'hFFFFFFFF;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    md_flush = 1'b1;
    @(posedge clk); #1;
    md_flush = 1'b0;
    check("flush_idle", {62'd0, md_busy, md_done}, 64'd0);
    seen_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (md_done) seen_done = 1'b1; end
    check("flush_no_done", {63'd0, seen_done}, 64'd0);
    check("flush_hilo", {md_hi, md_lo}, {32'h1234, 32'h5678});

    // Flush alongside a request in IDLE drops it.
    do_short("flush_mthi", 3'd4, 32'hAAAA5555, 1'b1);
    @(negedge clk);
    md_start = 1'b1; md_op = 3'd2; md_rs = 32'd9; md_rt = 32'd3; md_flush = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0; md_flush = 1'b0;
    check("flush_div_dropped", {63'd0, md_busy}, 64'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      rs = $urandom;
      case ($urandom_range(0, 3))
        0:       rt = 32'd0;
        1:       rt = 32'($urandom_range(0, 15));
        2:       rt = -32'($urandom_range(1, 15));
        default: rt = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) rs = 32'h80000000;
      if (op <= 3'd3) begin
        r = ref_md(op, rs, rt);
        run_muldiv($sformatf("rnd%0d_op%0d", i, op), op, rs, rt, r[63:32], r[31:0],
                   1'($urandom_range(0, 1)));
      end else begin
        do_short($sformatf("rnd%0d_op%0d", i, op), op, rs, 1'b0);
      end
    end

    // Reset in the middle of a MULT.
    do_short("pre_rst_mthi", 3'd4, 32'h0BAD0BAD, 1'b0);
    @(negedge clk);
    md_start = 1'b1; md_op = 3'd0; md_rs = 32'hFFFFFFFD; md_rt = 32'd7;
    @(posedge clk); #1;
    md_start = 1'b0;
    k = 0;
    while (k < 9) begin @(posedge clk); #1; k++; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_op", {md_busy, md_done, md_hi, md_lo}, 66'd0);
    @(negedge clk); rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (md_done || md_busy) seen_done = 1'b1; end
    check("rst_no_done", {63'd0, seen_done}, 64'd0);
    check("rst_hilo", {md_hi, md_lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
